vga_display_engine: RTL
=======================

VGA_DISPLAY_ENGINE -- requirements
Module: vga_display_engine

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical porch and sync widths in lines.
REQ-005 SHALL have parameter FB_BASE, default 32'h0000_0100: byte address of framebuffer word 0.
REQ-006 SHALL have parameter MEM_LAT, default 1, legal 0..3: framebuffer read latency in pixel ticks.
REQ-007 SHALL have parameter SCALE_LOG2, default 2, legal 0..3: pixel replication factor 2^SCALE_LOG2 in x and y.
REQ-008 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-high.
REQ-009 SHALL have ports: pix_en in 1, pixel-tick enable; all counters and pipeline stages advance only when pix_en=1.
REQ-010 SHALL have ports: mode_req in 2, requested mode (0 external RGB, 1 framebuffer, 2 solid colour, 3 reserved = solid).
REQ-011 SHALL have ports: ext_r/ext_g/ext_b in 8 each, external generator colour for the current x,y.
REQ-012 SHALL have ports: solid_rgb in 24, colour for mode 2.
REQ-013 SHALL have ports: fb_addr out 32, fb_rdata in 32 (pixel = bits 23:0, R in 23:16).
REQ-014 SHALL have ports: x out 10, y out 10, the undelayed counters, which ext_* is computed from.
REQ-015 SHALL have ports: hsync, vsync, sync_b, blank_b out 1 each, all active-low; r, g, b out 8 each.
REQ-016 SHALL have ports: frame_irq out 1, one-clk pulse; frame_count out 16.

Function
REQ-017 SHALL count hcnt 0..H_TOTAL-1, where H_TOTAL = sum of the H widths, and vcnt 0..V_TOTAL-1, wrapping; vcnt increments on hcnt wrap.
REQ-018 SHALL assert raw hsync low for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-019 SHALL assert raw vsync low for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-020 SHALL set raw blank_b=1 only for hcnt<H_ACTIVE and vcnt<V_ACTIVE; sync_b SHALL equal hsync AND vsync.
REQ-021 SHALL drive fb_addr combinationally as FB_BASE + 4*((vcnt>>S)*(H_ACTIVE>>S) + (hcnt>>S)), S=SCALE_LOG2; during blanking it SHALL hold the last visible address.
REQ-022 SHALL delay hsync, vsync, blank_b and the active mode by exactly MEM_LAT pixel ticks plus one output register, so that colour and sync stay aligned.
REQ-023 SHALL have registered outputs; with MEM_LAT=0, outputs lag x,y by one pixel tick.
REQ-024 SHALL force r,g,b to 0 whenever the delayed blank_b=0.
REQ-025 SHALL latch mode_req into the active-mode register only on the tick where vcnt changes from V_ACTIVE-1 to V_ACTIVE (start of vertical blank); mid-frame changes SHALL NOT affect the current frame.
REQ-026 SHALL pulse frame_irq for one clk on that same tick, and increment frame_count there, wrapping at 16'hFFFF to 0.
REQ-027 With pix_en=0, the engine SHALL hold all state and outputs, and frame_irq SHALL stay 0.

Reset
REQ-028 SHALL, on asynchronous reset, set hcnt=vcnt=0, active mode=0, the pipeline to blank (blank_b=0, hsync=vsync=sync_b=1), r=g=b=0, frame_irq=0 and frame_count=0.
REQ-029 SHALL restart reset released mid-frame at hcnt=vcnt=0, with no partial frame_irq.

Structure
REQ-030 SHALL define a shared package vga_pkg holding the mode enum (MODE_EXT, MODE_FB, MODE_SOLID), the default 640x480 timing constants, and the RGB888 struct.
REQ-031 SHALL instantiate the counters and raw sync/blank generation as sub-module vga_timing; vga_display_engine adds the fetch, the alignment pipeline and mode control.

Verification
REQ-032 Defaults, pix_en=1: hsync SHALL be low for 96 ticks starting at hcnt 656 (+1+MEM_LAT lag); line period SHALL be 800; frame period SHALL be 420000 ticks.
REQ-033 Mode 1, SCALE_LOG2=2: at x=9,y=5, fb_addr SHALL be 32'h100+4*(1*160+2)=32'h388; fb_rdata=32'h00AABBCC SHALL yield r=AA g=BB b=CC, 2 ticks later.
REQ-034 mode_req switched 0->2 at y=100: the rest of the frame SHALL stay external; the next frame SHALL show solid_rgb; frame_irq SHALL pulse once per frame.
REQ-035 pix_en toggling 1,0,1,0: timing SHALL be stretched 2x and outputs SHALL hold during pix_en=0.
REQ-036 Reset asserted at y=200: all outputs SHALL be at reset values immediately; after release, frame_count SHALL be 0 and the first frame_irq SHALL come 480 lines later.
REQ-037 frame_count preloaded near wrap (force 16'hFFFF): the next vblank SHALL give 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA display engine.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_FB    = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // One pixel's worth of state carried through the fetch-latency delay line.
  typedef struct packed {
    logic    hsync;
    logic    vsync;
    logic    blank_b;
    mode_e   mode;
    rgb888_t ext;
  } pix_stage_t;

  localparam pix_stage_t STAGE_BLANK = '{hsync: 1'b1, vsync: 1'b1, blank_b: 1'b0,
                                         mode: MODE_EXT, ext: '0};

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with raw (undelayed) sync and blank generation.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       blank_raw_b,
  output logic       vblank_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last;
  logic v_last;

  assign h_last = (hcnt == 10'(H_TOTAL - 1));
  assign v_last = (vcnt == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcnt <= '0;
        vcnt <= v_last ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  always_comb begin
    hsync_raw    = !((hcnt >= 10'(H_ACTIVE + H_FP)) && (hcnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_raw    = !((vcnt >= 10'(V_ACTIVE + V_FP)) && (vcnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
    blank_raw_b  = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    vblank_start = pix_en && h_last && (vcnt == 10'(V_ACTIVE - 1));
  end

endmodule

// File: rtl/vga_display_engine.sv
// VGA engine: timing, framebuffer fetch, latency-matched sync/colour pipeline, mode control.
module vga_display_engine
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic [31:0] FB_BASE    = 32'h0000_0100,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic [1:0]  mode_req,
  input  logic [7:0]  ext_r,
  input  logic [7:0]  ext_g,
  input  logic [7:0]  ext_b,
  input  logic [23:0] solid_rgb,
  output logic [31:0] fb_addr,
  input  logic [31:0] fb_rdata,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        sync_b,
  output logic        blank_b,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frame_irq,
  output logic [15:0] frame_count
);

  localparam int unsigned FB_COLS = H_ACTIVE >> SCALE_LOG2;

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        blank_raw_b;
  logic        vblank_start;
  logic [31:0] addr_calc;
  logic [31:0] last_addr_q;
  mode_e       mode_q;
  logic [15:0] frame_cnt_q;
  pix_stage_t  cur;
  pix_stage_t  dly;
  rgb888_t     pix_rgb;
  logic        fb_rdata_unused;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .hsync_raw    (hsync_raw),
    .vsync_raw    (vsync_raw),
    .blank_raw_b  (blank_raw_b),
    .vblank_start (vblank_start)
  );

  assign x               = hcnt;
  assign y               = vcnt;
  assign fb_rdata_unused = ^fb_rdata[31:24];

  always_comb begin
    addr_calc = FB_BASE + ((32'(vcnt >> SCALE_LOG2) * 32'(FB_COLS) + 32'(hcnt >> SCALE_LOG2)) << 2);
  end

  // Blanking presents the last visible address so the memory sees no spurious jumps.
  assign fb_addr = blank_raw_b ? addr_calc : last_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr_q <= FB_BASE;
    end else if (pix_en && blank_raw_b) begin
      last_addr_q <= addr_calc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= MODE_EXT;
      frame_cnt_q <= '0;
      frame_irq   <= 1'b0;
    end else begin
      frame_irq <= vblank_start;
      if (vblank_start) begin
        mode_q      <= mode_e'(mode_req);
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_count = frame_cnt_q;

  always_comb begin
    cur         = STAGE_BLANK;
    cur.hsync   = hsync_raw;
    cur.vsync   = vsync_raw;
    cur.blank_b = blank_raw_b;
    cur.mode    = mode_q;
    cur.ext     = {ext_r, ext_g, ext_b};
  end

  // Sync, blank, mode and external colour ride alongside the fetch for MEM_LAT ticks.
  if (MEM_LAT == 0) begin : g_nolat
    assign dly = cur;
  end else begin : g_lat
    pix_stage_t pipe_q [MEM_LAT];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned i = 0; i < MEM_LAT; i++) pipe_q[i] <= STAGE_BLANK;
      end else if (pix_en) begin
        pipe_q[0] <= cur;
        for (int unsigned i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign dly = pipe_q[MEM_LAT-1];
  end

  always_comb begin
    pix_rgb = '0;
    case (dly.mode)
      MODE_EXT: pix_rgb = dly.ext;
      MODE_FB:  pix_rgb = fb_rdata[23:0];
      default:  pix_rgb = solid_rgb;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      sync_b  <= 1'b1;
      blank_b <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else if (pix_en) begin
      hsync     <= dly.hsync;
      vsync     <= dly.vsync;
      sync_b    <= dly.hsync & dly.vsync;
      blank_b   <= dly.blank_b;
      {r, g, b} <= dly.blank_b ? pix_rgb : 24'h0;
    end
  end

endmodule
